// File: rtl/sudoku_pkg.sv
// Shared definitions for the Sudoku grid engine: FSM state encoding,
// default box size and a constant-evaluable clog2 helper.
package sudoku_pkg;

  localparam int BOX_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_PLAY   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_SOLVED = 3'd4
  } state_t;

  // Smallest r with 2**r >= n; usable in parameter and port-width expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sudoku_check_scan.sv
// Sequential solve checker: walks the grid one cell per cycle, counts cells
// where the player value differs from the solution, then publishes the count
// with a one-cycle done pulse one cycle after the last comparison.
module sudoku_check_scan #(
  parameter int CELLS = 16,
  parameter int VW    = 3,
  parameter int CW    = 4,
  parameter int MW    = 5
) (
  input  logic                i_clka,
  input  logic                i_restart,
  input  logic                i_abort,
  input  logic                i_start,
  input  logic [CELLS*VW-1:0] i_user_board,
  input  logic [CELLS*VW-1:0] i_real_board,
  output logic                o_fin,
  output logic                o_acc_zero,
  output logic                o_done,
  output logic [MW-1:0]       o_mismatch_cnt
);

  logic          r_busy;
  logic [CW-1:0] r_idx;
  logic [MW-1:0] r_acc;
  logic          r_fin;
  logic          r_done;
  logic [MW-1:0] r_cnt;

  logic [VW-1:0] w_user_v;
  logic [VW-1:0] w_real_v;
  logic          w_diff;
  logic          w_last;

  // Select the cell under scan and compare it.
  always_comb begin
    w_user_v = i_user_board[int'(r_idx)*VW +: VW];
    w_real_v = i_real_board[int'(r_idx)*VW +: VW];
    w_diff   = (w_user_v != w_real_v);
    w_last   = r_busy && (r_idx == CW'(CELLS - 1));
  end

  // Scan counter, mismatch accumulator and result/done registers.
  // An abort (new game) drops any scan in flight without a done pulse.
  always_ff @(posedge i_clka) begin
    if (i_restart) begin
      r_busy <= 1'b0;
      r_idx  <= '0;
      r_acc  <= '0;
      r_fin  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
      r_idx  <= '0;
      r_acc  <= '0;
      r_fin  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= r_fin;
      r_fin  <= 1'b0;
      if (r_fin) r_cnt <= r_acc;
      if (i_start) begin
        r_busy <= 1'b1;
        r_idx  <= '0;
        r_acc  <= '0;
      end else if (r_busy) begin
        r_acc <= r_acc + MW'(w_diff);
        if (w_last) begin
          r_busy <= 1'b0;
          r_fin  <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign o_fin          = r_fin;
  assign o_acc_zero     = (r_acc == '0);
  assign o_done         = r_done;
  assign o_mismatch_cnt = r_cnt;

endmodule

// File: rtl/sudoku_grid_engine.sv
// Sudoku board store: solution and player grids, hint mask, serial puzzle
// load, protected player writes with reject signalling and a sequential
// solve check delegated to sudoku_check_scan.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | after reset, waiting for new_game
//   ST_LOAD   | accepting CELLS solution values/hint bits in row-major order
//   ST_PLAY   | player captures row/col and writes values
//   ST_CHECK  | scanning grid for mismatches, play inputs ignored
//   ST_SOLVED | last check found no mismatch, grids frozen
module sudoku_grid_engine
  import sudoku_pkg::*;
#(
  parameter int BOX = BOX_DEF,
  parameter int VW  = 3,
  parameter int IW  = 2
) (
  input  logic                                   i_clka,
  input  logic                                   i_restart,
  input  logic                                   i_new_game,
  input  logic                                   i_load_valid,
  input  logic [VW-1:0]                          i_load_val,
  input  logic                                   i_load_hint,
  input  logic                                   i_row_flag,
  input  logic                                   i_col_flag,
  input  logic                                   i_val_flag,
  input  logic                                   i_check_flag,
  input  logic [VW-1:0]                          i_cell_data,
  output logic [BOX*BOX*BOX*BOX*VW-1:0]          o_user_board,
  output logic [BOX*BOX*BOX*BOX*VW-1:0]          o_real_board,
  output logic [BOX*BOX*BOX*BOX-1:0]             o_fill_flag,
  output logic [2:0]                             o_state_o,
  output logic                                   o_reject,
  output logic                                   o_check_done,
  output logic [clog2(BOX*BOX*BOX*BOX+1)-1:0]    o_mismatch_cnt,
  output logic                                   o_solved
);

  localparam int SIDE  = BOX * BOX;
  localparam int CELLS = SIDE * SIDE;
  localparam int CW    = clog2(CELLS);
  localparam int MW    = clog2(CELLS + 1);
  localparam logic [VW-1:0] LP_SIDE_V = VW'(SIDE);

  state_t           r_state;
  logic [CW-1:0]    r_load_idx;
  logic [IW-1:0]    r_row;
  logic [IW-1:0]    r_col;
  logic             r_reject;
  logic             r_solved;
  logic [VW-1:0]    r_user [CELLS];
  logic [VW-1:0]    r_real [CELLS];
  logic [CELLS-1:0] r_fill;

  logic [CW-1:0]    w_cell;
  logic             w_val_ok;
  logic             w_pos_ok;
  logic             w_load_bad;
  logic             w_start;
  logic             w_scan_fin;
  logic             w_acc_zero;

  // Decode of the player bus against the current row/col and hint mask.
  always_comb begin
    w_cell     = CW'(r_row) * CW'(SIDE) + CW'(r_col);
    w_val_ok   = (i_cell_data <= LP_SIDE_V) && !r_fill[w_cell];
    w_pos_ok   = (i_cell_data < LP_SIDE_V);
    w_load_bad = (i_load_val == '0) || (i_load_val > LP_SIDE_V);
    // A check starts only when no capture/write shares the cycle.
    w_start    = (r_state == ST_PLAY) && i_check_flag && !i_val_flag &&
                 !i_col_flag && !i_row_flag && !i_new_game;
  end

  // Main FSM with grid storage and registered reject/solved outputs.
  always_ff @(posedge i_clka) begin
    if (i_restart) begin
      r_state    <= ST_IDLE;
      r_load_idx <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_reject   <= 1'b0;
      r_solved   <= 1'b0;
      r_fill     <= '0;
      for (int k = 0; k < CELLS; k++) begin
        r_user[k] <= '0;
        r_real[k] <= '0;
      end
    end else begin
      r_reject <= 1'b0;
      if (i_new_game) begin
        r_state    <= ST_LOAD;
        r_load_idx <= '0;
        r_solved   <= 1'b0;
        r_fill     <= '0;
        for (int k = 0; k < CELLS; k++) begin
          r_user[k] <= '0;
          r_real[k] <= '0;
        end
      end else begin
        case (r_state)
          ST_LOAD: begin
            if (i_load_valid) begin
              r_real[r_load_idx] <= i_load_val;
              r_fill[r_load_idx] <= i_load_hint;
              r_user[r_load_idx] <= i_load_hint ? i_load_val : '0;
              r_reject           <= w_load_bad;
              r_load_idx         <= r_load_idx + 1'b1;
              if (r_load_idx == CW'(CELLS - 1)) r_state <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (i_val_flag) begin
              if (w_val_ok) r_user[w_cell] <= i_cell_data;
              else          r_reject       <= 1'b1;
            end else if (i_col_flag) begin
              if (w_pos_ok) r_col    <= i_cell_data[IW-1:0];
              else          r_reject <= 1'b1;
            end else if (i_row_flag) begin
              if (w_pos_ok) r_row    <= i_cell_data[IW-1:0];
              else          r_reject <= 1'b1;
            end
            if (w_start) r_state <= ST_CHECK;
          end
          ST_CHECK: begin
            if (w_scan_fin) begin
              r_solved <= w_acc_zero;
              r_state  <= w_acc_zero ? ST_SOLVED : ST_PLAY;
            end
          end
          ST_SOLVED: begin
            if (i_val_flag) r_reject <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Flatten grids onto the packed output buses, cell k at [k*VW +: VW].
  always_comb begin
    o_user_board = '0;
    o_real_board = '0;
    for (int k = 0; k < CELLS; k++) begin
      o_user_board[k*VW +: VW] = r_user[k];
      o_real_board[k*VW +: VW] = r_real[k];
    end
  end

  sudoku_check_scan #(
    .CELLS (CELLS),
    .VW    (VW),
    .CW    (CW),
    .MW    (MW)
  ) u_scan (
    .i_clka         (i_clka),
    .i_restart      (i_restart),
    .i_abort        (i_new_game),
    .i_start        (w_start),
    .i_user_board   (o_user_board),
    .i_real_board   (o_real_board),
    .o_fin          (w_scan_fin),
    .o_acc_zero     (w_acc_zero),
    .o_done         (o_check_done),
    .o_mismatch_cnt (o_mismatch_cnt)
  );

  assign o_fill_flag = r_fill;
  assign o_state_o   = r_state;
  assign o_reject    = r_reject;
  assign o_solved    = r_solved;

endmodule

// File: tb/tb_sudoku_grid_engine.sv
// Bench for sudoku_grid_engine (BOX=2, VW=3): directed scenario with literal
// expectations, then randomized traffic, all compared every cycle against a
// behavioural grid model.
module tb_sudoku_grid_engine;

  localparam int SIDE  = 4;
  localparam int CELLS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        restart, new_game, load_valid, load_hint;
  logic        row_flag, col_flag, val_flag, check_flag;
  logic [2:0]  load_val, cell_data;
  logic [47:0] o_user_board, o_real_board;
  logic [15:0] o_fill_flag;
  logic [2:0]  o_state_o;
  logic        o_reject, o_check_done, o_solved;
  logic [4:0]  o_mismatch_cnt;

  sudoku_grid_engine #(.BOX(2), .VW(3), .IW(2)) dut (
    .i_clka         (clk),
    .i_restart      (restart),
    .i_new_game     (new_game),
    .i_load_valid   (load_valid),
    .i_load_val     (load_val),
    .i_load_hint    (load_hint),
    .i_row_flag     (row_flag),
    .i_col_flag     (col_flag),
    .i_val_flag     (val_flag),
    .i_check_flag   (check_flag),
    .i_cell_data    (cell_data),
    .o_user_board   (o_user_board),
    .o_real_board   (o_real_board),
    .o_fill_flag    (o_fill_flag),
    .o_state_o      (o_state_o),
    .o_reject       (o_reject),
    .o_check_done   (o_check_done),
    .o_mismatch_cnt (o_mismatch_cnt),
    .o_solved       (o_solved)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // Behavioural model state (state numbers: IDLE 0, LOAD 1, PLAY 2, CHECK 3, SOLVED 4)
  int m_user [CELLS];
  int m_real [CELLS];
  bit m_hint [CELLS];
  int m_state, m_row, m_col, m_idx, m_timer, m_pend, m_mm;
  bit m_solved, m_rej, m_done;

  int g_sol [CELLS] = '{1,2,3,4, 3,4,1,2, 2,1,4,3, 4,3,2,1};

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] pack_user();
    logic [47:0] b = '0;
    for (int k = 0; k < CELLS; k++) b[k*3 +: 3] = 3'(m_user[k]);
    return b;
  endfunction

  function automatic logic [47:0] pack_real();
    logic [47:0] b = '0;
    for (int k = 0; k < CELLS; k++) b[k*3 +: 3] = 3'(m_real[k]);
    return b;
  endfunction

  function automatic logic [15:0] pack_hint();
    logic [15:0] b = '0;
    for (int k = 0; k < CELLS; k++) b[k] = m_hint[k];
    return b;
  endfunction

  task automatic clear_grids();
    for (int k = 0; k < CELLS; k++) begin
      m_user[k] = 0;
      m_real[k] = 0;
      m_hint[k] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int d, k;
    m_rej  = 0;
    m_done = 0;
    d = int'(cell_data);
    if (restart) begin
      clear_grids();
      m_state = 0; m_row = 0; m_col = 0; m_idx = 0;
      m_timer = 0; m_solved = 0; m_mm = 0;
    end else if (new_game) begin
      clear_grids();
      m_state = 1; m_idx = 0; m_timer = 0; m_solved = 0; m_mm = 0;
    end else begin
      case (m_state)
        1: if (load_valid) begin
          m_real[m_idx] = int'(load_val);
          m_hint[m_idx] = load_hint;
          m_user[m_idx] = load_hint ? int'(load_val) : 0;
          m_rej = (load_val == 0) || (int'(load_val) > SIDE);
          if (m_idx == CELLS - 1) m_state = 2;
          m_idx++;
        end
        2: begin
          if (val_flag) begin
            k = m_row * SIDE + m_col;
            if (d <= SIDE && !m_hint[k]) m_user[k] = d;
            else m_rej = 1;
          end else if (col_flag) begin
            if (d < SIDE) m_col = d; else m_rej = 1;
          end else if (row_flag) begin
            if (d < SIDE) m_row = d; else m_rej = 1;
          end
          if (check_flag && !val_flag && !col_flag && !row_flag) begin
            m_state = 3;
            m_timer = CELLS + 1;
            m_pend = 0;
            for (int j = 0; j < CELLS; j++) if (m_user[j] != m_real[j]) m_pend++;
          end
        end
        3: begin
          m_timer--;
          if (m_timer == 0) begin
            m_done   = 1;
            m_mm     = m_pend;
            m_solved = (m_pend == 0);
            m_state  = m_solved ? 4 : 2;
          end
        end
        4: if (val_flag) m_rej = 1;
        default: ;
      endcase
    end
  endtask

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check_val("state",        64'(o_state_o),      64'(m_state));
      check_val("reject",       64'(o_reject),       64'(m_rej));
      check_val("check_done",   64'(o_check_done),   64'(m_done));
      check_val("mismatch_cnt", 64'(o_mismatch_cnt), 64'(m_mm));
      check_val("solved",       64'(o_solved),       64'(m_solved));
      check_val("user_board",   64'(o_user_board),   64'(pack_user()));
      check_val("real_board",   64'(o_real_board),   64'(pack_real()));
      check_val("fill_flag",    64'(o_fill_flag),    64'(pack_hint()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clr_in();
    restart = 0; new_game = 0; load_valid = 0; load_val = 0; load_hint = 0;
    row_flag = 0; col_flag = 0; val_flag = 0; check_flag = 0; cell_data = 0;
  endtask

  task automatic load_std();
    new_game = 1; cyc(); new_game = 0;
    for (int k = 0; k < CELLS; k++) begin
      load_valid = 1;
      load_val   = 3'(g_sol[k]);
      load_hint  = (k % 5 == 0);
      cyc();
    end
    load_valid = 0; load_hint = 0; load_val = 0;
  endtask

  task automatic play_write(input int r, input int c, input int v, output bit rej);
    row_flag = 1; cell_data = 3'(r); cyc(); row_flag = 0;
    col_flag = 1; cell_data = 3'(c); cyc(); col_flag = 0;
    val_flag = 1; cell_data = 3'(v); cyc(); val_flag = 0;
    rej = o_reject;
    cell_data = 0;
  endtask

  // Issue a check and count cycles until check_done, bounded.
  task automatic run_check(output int n);
    bit seen = 0;
    check_flag = 1; cyc(); check_flag = 0;
    n = 0;
    while (n < 40 && !seen) begin
      cyc();
      n++;
      if (o_check_done) seen = 1;
    end
  endtask

  initial begin
    bit rej;
    int n, v, dones;

    clr_in();
    restart = 1;
    chk_en  = 1;
    cyc();
    restart = 0;
    repeat (3) cyc();
    check_val("rst_state_lit", 64'(o_state_o), 64'd0);
    check_val("rst_user_lit",  64'(o_user_board), 64'd0);
    check_val("rst_mm_lit",    64'(o_mismatch_cnt), 64'd0);

    load_std();
    check_val("fill_lit",  64'(o_fill_flag), 64'h8421);
    check_val("hints_lit", 64'(o_user_board),
              64'd1 | (64'd4 << 15) | (64'd4 << 30) | (64'd1 << 45));
    check_val("play_lit",  64'(o_state_o), 64'd2);

    play_write(0, 0, 3, rej);
    check_val("hint_reject_lit", 64'(rej), 64'd1);
    check_val("hint_kept_lit",   64'(o_user_board[2:0]), 64'd1);
    play_write(0, 1, 2, rej);
    check_val("write_ok_lit",    64'(rej), 64'd0);
    check_val("cell1_lit",       64'(o_user_board[5:3]), 64'd2);

    row_flag = 1; cell_data = 3'd5; cyc(); row_flag = 0;
    check_val("row5_reject_lit", 64'(o_reject), 64'd1);
    val_flag = 1; cell_data = 3'd7; cyc(); val_flag = 0;
    check_val("val7_reject_lit", 64'(o_reject), 64'd1);
    check_val("val7_nowrite_lit", 64'(o_user_board[5:3]), 64'd2);
    val_flag = 1; cell_data = 3'd0; cyc(); val_flag = 0;
    check_val("erase_lit", 64'(o_user_board[5:3]), 64'd0);

    for (int k = 0; k < CELLS; k++)
      if (k % 5 != 0) play_write(k / 4, k % 4, g_sol[k], rej);
    run_check(n);
    check_val("done_latency_lit", 64'(n), 64'd17);
    check_val("solved_mm_lit",    64'(o_mismatch_cnt), 64'd0);
    check_val("solved_lit",       64'(o_solved), 64'd1);
    check_val("solved_state_lit", 64'(o_state_o), 64'd4);
    play_write(1, 0, 4, rej);
    check_val("solved_reject_lit", 64'(rej), 64'd1);

    load_std();
    for (int k = 0; k < CELLS; k++) begin
      if (k % 5 != 0) begin
        v = g_sol[k];
        if (k == 1) v = 3;
        if (k == 2) v = 2;
        play_write(k / 4, k % 4, v, rej);
      end
    end
    run_check(n);
    check_val("wrong_latency_lit", 64'(n), 64'd17);
    check_val("wrong_mm_lit",      64'(o_mismatch_cnt), 64'd2);
    check_val("wrong_solved_lit",  64'(o_solved), 64'd0);
    check_val("wrong_state_lit",   64'(o_state_o), 64'd2);

    check_flag = 1; cyc(); check_flag = 0;
    repeat (8) cyc();
    restart = 1; cyc(); restart = 0;
    dones = 0;
    repeat (25) begin
      cyc();
      if (o_check_done) dones++;
    end
    check_val("abort_nodone_lit", 64'(dones), 64'd0);
    check_val("abort_state_lit",  64'(o_state_o), 64'd0);

    for (int i = 0; i < 4000; i++) begin
      restart    = ($urandom_range(0, 599) == 0);
      new_game   = ($urandom_range(0, 149) == 0) || (m_state == 0 && $urandom_range(0, 3) == 0);
      load_valid = ($urandom_range(0, 1) == 1);
      load_val   = 3'($urandom_range(0, 7));
      load_hint  = ($urandom_range(0, 2) == 0);
      row_flag   = ($urandom_range(0, 3) == 0);
      col_flag   = ($urandom_range(0, 3) == 0);
      val_flag   = ($urandom_range(0, 3) == 0);
      check_flag = ($urandom_range(0, 9) == 0);
      cell_data  = 3'($urandom_range(0, 7));
      cyc();
    end
    clr_in();
    cyc();

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
